// File: rtl/mont_iter_core.sv
// Radix-2 bit-serial Montgomery iteration: T = A*B*2^-K_BITS mod M, left in [0, 2M).
// Produces one result every K_BITS+2 cycles for the downstream T - M subtractor.
module mont_iter_core #(
  parameter int K_BITS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [K_BITS-1:0] i_A,
  input  logic [K_BITS-1:0] i_B,
  input  logic [K_BITS-1:0] i_M,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_valid,
  output logic [K_BITS:0]   o_T,
  output logic [K_BITS:0]   o_M
);

  localparam int CW = (K_BITS > 1) ? $clog2(K_BITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [K_BITS-1:0]   a_sh;
  logic [K_BITS-1:0]   b_reg;
  logic [K_BITS-1:0]   m_reg;
  logic [K_BITS:0]     t_reg;
  logic [K_BITS:0]     t_next;
  logic                last_iter;

  // Intermediate sum is < 4M, so it needs K_BITS+2 bits before the halving shift.
  function automatic logic [K_BITS:0] mont_step(input logic [K_BITS:0]   t,
                                                input logic              a,
                                                input logic [K_BITS-1:0] b,
                                                input logic [K_BITS-1:0] m);
    logic              q;
    logic [K_BITS+1:0] sum;
    q   = t[0] ^ (a & b[0]);
    sum = {1'b0, t} + (a ? {2'b00, b} : '0) + (q ? {2'b00, m} : '0);
    return sum[K_BITS+1:1];
  endfunction

  assign t_next    = mont_step(t_reg, a_sh[0], b_reg, m_reg);
  assign last_iter = (cnt == CW'(K_BITS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      t_reg   <= '0;
      m_reg   <= '0;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            a_sh    <= i_A;
            b_reg   <= i_B;
            m_reg   <= i_M;
            t_reg   <= '0;
            cnt     <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // A is consumed LSB first by shifting it down one bit per iteration.
          t_reg <= t_next;
          a_sh  <= a_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_T = t_reg;
  assign o_M = {1'b0, m_reg};

endmodule

// File: tb/tb_mont_iter_core.sv
// Bench for mont_iter_core: directed K_BITS=8 vectors and handshake/reset sequences,
// plus random K_BITS=256 vectors against a modular-halving reference.
module tb_mont_iter_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         st8, rdy8, bsy8, vld8;
  logic [7:0]   a8, b8, m8;
  logic [8:0]   t8, om8;
  logic         st256, rdy256, bsy256, vld256;
  logic [255:0] a256, b256, m256;
  logic [256:0] t256, om256;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mont_iter_core #(.K_BITS(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(st8), .i_A(a8), .i_B(b8), .i_M(m8),
    .o_ready(rdy8), .o_busy(bsy8), .o_valid(vld8), .o_T(t8), .o_M(om8)
  );

  mont_iter_core #(.K_BITS(256)) dut256 (
    .i_clk(clk), .i_rst(rst), .i_start(st256), .i_A(a256), .i_B(b256), .i_M(m256),
    .o_ready(rdy256), .o_busy(bsy256), .o_valid(vld256), .o_T(t256), .o_M(om256)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [8:0] t;
  } vec_t;

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // A*B mod M, then halve modulo M 256 times to apply 2^-256.
  function automatic logic [255:0] ref_mont(input logic [255:0] a, b, m);
    logic [511:0] p;
    logic [257:0] x;
    p = ({256'b0, a} * {256'b0, b}) % {256'b0, m};
    x = p[257:0];
    for (int i = 0; i < 256; i++) x = x[0] ? ((x + {2'b00, m}) >> 1) : (x >> 1);
    return x[255:0];
  endfunction

  task automatic run8(input logic [7:0] a, b, m, output int nv, output int lat,
                      output logic [8:0] t, output logic [8:0] om);
    nv = 0; lat = -1; t = '0; om = '0;
    @(negedge clk); a8 = a; b8 = b; m8 = m; st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (vld8) begin
        nv++;
        if (lat < 0) begin lat = e; t = t8; om = om8; end
      end
    end
  endtask

  task automatic run256(input logic [255:0] a, b, m, output int nv, output int lat,
                        output logic [256:0] t, output logic [256:0] om);
    int e;
    nv = 0; lat = -1; t = '0; om = '0; e = 0;
    @(negedge clk); a256 = a; b256 = b; m256 = m; st256 = 1'b1;
    @(posedge clk); #1; st256 = 1'b0;
    while (e < 300 && (lat < 0 || e < lat + 2)) begin
      @(posedge clk); #1; e++;
      if (vld256) begin
        nv++;
        if (lat < 0) begin lat = e; t = t256; om = om256; end
      end
    end
  endtask

  vec_t         tbl [4];
  int           nv, lat, rdy_bad;
  logic [8:0]   tt, om;
  logic [256:0] tb, omb;
  logic [255:0] ra, rb, rm, rr;
  int           vld_e [$];
  logic [8:0]   vld_t [$];

  initial begin
    tbl[0] = '{a: 8'd5,   b: 8'd7,   m: 8'd239, t: 9'd227};
    tbl[1] = '{a: 8'd238, b: 8'd238, m: 8'd239, t: 9'd225};
    tbl[2] = '{a: 8'd1,   b: 8'd1,   m: 8'd239, t: 9'd225};
    tbl[3] = '{a: 8'd0,   b: 8'd200, m: 8'd239, t: 9'd0};

    rst = 1'b1; st8 = 1'b0; st256 = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; a256 = '0; b256 = '0; m256 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", rdy8, 1);
    check("rst_busy", bsy8, 0);
    check("rst_valid", vld8, 0);
    check("rst_T", t8, 0);
    check("rst_M", om8, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].m, nv, lat, tt, om);
      check($sformatf("vec%0d_T", i), tt, tbl[i].t);
      check($sformatf("vec%0d_npulse", i), nv, 1);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_M", i), om, {1'b0, tbl[i].m});
    end

    // Start held high; operands change mid-RUN and must only be picked up at the next accept.
    @(negedge clk); a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; st8 = 1'b1;
    @(posedge clk); #1;
    rdy_bad = 0;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin a8 = 8'd1; b8 = 8'd1; end
      if (vld8) begin vld_e.push_back(e); vld_t.push_back(t8); end
      if ((e % 10) == 9) begin
        check($sformatf("hs_ready_back_e%0d", e), rdy8, 1);
      end else if (rdy8 !== 1'b0 || bsy8 !== 1'b1) begin
        rdy_bad++;
      end
      if (e == 19) st8 = 1'b0;
    end
    check("hs_ready_low_busy_high", rdy_bad, 0);
    check("hs_npulse", vld_e.size(), 2);
    if (vld_e.size() == 2) begin
      check("hs_first_edge", vld_e[0], 8);
      check("hs_second_edge", vld_e[1], 18);
      check("hs_first_T", vld_t[0], 227);
      check("hs_second_T", vld_t[1], 225);
    end
    repeat (3) @(posedge clk);
    #1;
    check("hs_idle_ready", rdy8, 1);

    // Reset lands on the edge that would perform iteration 4.
    @(negedge clk); a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rstmid_T", t8, 0);
    check("rstmid_ready", rdy8, 1);
    check("rstmid_M", om8, 0);
    nv = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (vld8) nv++;
    end
    check("rstmid_no_pulse", nv, 0);
    run8(8'd5, 8'd7, 8'd239, nv, lat, tt, om);
    check("rstmid_restart_T", tt, 227);
    check("rstmid_restart_latency", lat, 8);

    for (int v = 0; v < 60; v++) begin
      rm = rnd256() | 256'd1;
      ra = rnd256() % rm;
      rb = rnd256() % rm;
      rr = ref_mont(ra, rb, rm);
      run256(ra, rb, rm, nv, lat, tb, omb);
      check($sformatf("rnd%0d_npulse", v), nv, 1);
      check($sformatf("rnd%0d_latency", v), lat, 256);
      check($sformatf("rnd%0d_lt2M", v), ({1'b0, tb} < {1'b0, rm, 1'b0}), 1);
      check($sformatf("rnd%0d_modM", v), tb % {1'b0, rm}, rr);
      check($sformatf("rnd%0d_M", v), omb, {1'b0, rm});
      check($sformatf("rnd%0d_sub", v), (tb >= omb) ? (tb - omb) : tb, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
